// File: rtl/lut_layer_sched.sv
// Time-multiplexed LogicNets layer: one 8-input truth-table lookup per cycle, output valid NEURONS+1 edges after accept.
// Backpressure: output vector held in OUT until out_ready; in_ready is low whenever not IDLE.
module lut_layer_sched #(
  parameter int NEURONS = 16,
  parameter int IN_W    = 64,
  parameter int IDX_W   = 6,
  parameter int FANIN   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_vec,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NEURONS-1:0]         out_vec,
  output logic                       busy,
  input  logic                       cfg_tt_we,
  input  logic                       cfg_conn_we,
  input  logic [$clog2(NEURONS)-1:0] cfg_neuron,
  input  logic [FANIN-1:0]           cfg_tt_addr,
  input  logic                       cfg_tt_bit,
  input  logic [$clog2(FANIN)-1:0]   cfg_conn_slot,
  input  logic [IDX_W-1:0]           cfg_conn_idx,
  output logic                       cfg_drop
);

  localparam int NW = $clog2(NEURONS);
  localparam logic [NW-1:0] N_LAST = NW'(NEURONS - 1);

  typedef enum logic [1:0] {IDLE, RUN, LAST, OUT} state_t;

  state_t state, state_nx;

  logic [NW-1:0]      n, rd_idx;
  logic [IN_W-1:0]    in_q;
  logic               rd_q;
  logic [FANIN-1:0]   addr;
  logic               lut_bit;
  logic               nrn_ok, cfg_ok;

  logic [2**FANIN-1:0] tt   [NEURONS];
  logic [IDX_W-1:0]    conn [NEURONS][FANIN];

  assign nrn_ok = ({1'b0, cfg_neuron} < (NW+1)'(NEURONS));
  assign cfg_ok = (state == IDLE) && nrn_ok;

  // Slot j of the fan-in map supplies address bit j; unmapped indices read 0.
  always_comb begin
    addr = '0;
    for (int j = 0; j < FANIN; j++) begin
      if (int'(conn[n][j]) < IN_W) addr[j] = in_q[conn[n][j]];
    end
    lut_bit = tt[n][addr];
  end

  // Table storage survives reset.
  always_ff @(posedge clk) begin
    if (cfg_ok && cfg_tt_we)   tt[cfg_neuron][cfg_tt_addr]     <= cfg_tt_bit;
    if (cfg_ok && cfg_conn_we) conn[cfg_neuron][cfg_conn_slot] <= cfg_conn_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nx = RUN;
      end
      RUN:  if (n == N_LAST) state_nx = LAST;
      LAST: state_nx = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Lookup result lands in rd_q one edge after issue and is retired the following edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q     <= '0;
      n        <= '0;
      rd_q     <= 1'b0;
      rd_idx   <= '0;
      out_vec  <= '0;
      cfg_drop <= 1'b0;
    end else begin
      cfg_drop <= (cfg_tt_we || cfg_conn_we) && !cfg_ok;
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_q <= in_vec;
            n    <= '0;
          end
        end
        RUN: begin
          rd_q   <= lut_bit;
          rd_idx <= n;
          if (n != '0) out_vec[rd_idx] <= rd_q;
          n <= (n == N_LAST) ? '0 : n + 1'b1;
        end
        LAST: out_vec[rd_idx] <= rd_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_layer_sched.sv
// Directed and random-gap checks of lut_layer_sched against hand-computed values and a truth-table model.
module tb_lut_layer_sched;
  localparam int NEURONS = 16;
  localparam int IN_W    = 64;
  localparam int IDX_W   = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [63:0] in_vec;
  logic [15:0] out_vec;
  logic        cfg_tt_we, cfg_conn_we, cfg_tt_bit, cfg_drop;
  logic [3:0]  cfg_neuron;
  logic [7:0]  cfg_tt_addr;
  logic [2:0]  cfg_conn_slot;
  logic [5:0]  cfg_conn_idx;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  bit m_tt   [NEURONS][256];
  int m_conn [NEURONS][8];

  lut_layer_sched #(.NEURONS(NEURONS), .IN_W(IN_W), .IDX_W(IDX_W), .FANIN(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
    .busy(busy),
    .cfg_tt_we(cfg_tt_we), .cfg_conn_we(cfg_conn_we), .cfg_neuron(cfg_neuron),
    .cfg_tt_addr(cfg_tt_addr), .cfg_tt_bit(cfg_tt_bit),
    .cfg_conn_slot(cfg_conn_slot), .cfg_conn_idx(cfg_conn_idx),
    .cfg_drop(cfg_drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] model(input logic [63:0] v);
    logic [15:0] r;
    logic [7:0]  a;
    r = '0;
    for (int n = 0; n < NEURONS; n++) begin
      a = '0;
      for (int j = 0; j < 8; j++)
        if (m_conn[n][j] < IN_W) a[j] = v[m_conn[n][j]];
      r[n] = m_tt[n][a];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input int n, input int a, input bit b, input bit conn_en, input int slot, input int idx);
    cfg_tt_we     = 1'b1;
    cfg_conn_we   = conn_en;
    cfg_neuron    = 4'(n);
    cfg_tt_addr   = 8'(a);
    cfg_tt_bit    = b;
    cfg_conn_slot = 3'(slot);
    cfg_conn_idx  = 6'(idx);
    tick();
    cfg_tt_we   = 1'b0;
    cfg_conn_we = 1'b0;
    m_tt[n][a] = b;
    if (conn_en) m_conn[n][slot] = idx;
  endtask

  // cfg_at: pulse cfg_tt_we on the edge accept+cfg_at (0 = accept edge), -1 for none.
  task automatic run_one(input logic [63:0] vec, input int in_gap, input int rdy_gap, input int cfg_at,
                         output logic [15:0] res, output int lat, output int acc,
                         output logic drop, output logic drop_after);
    int t;
    t = 0; lat = 0; drop = 1'b0; drop_after = 1'b0;
    repeat (in_gap) tick();
    in_vec   = vec;
    in_valid = 1'b1;
    if (rdy_gap == 0) out_ready = 1'b1;
    while (!in_ready && t < 100) begin
      tick();
      t++;
    end
    if (cfg_at == 0) cfg_tt_we = 1'b1;
    tick();
    acc       = cyc;
    in_valid  = 1'b0;
    cfg_tt_we = 1'b0;
    if (cfg_at == 0) drop = cfg_drop;
    while (!out_valid && lat < 100) begin
      if (lat + 1 == cfg_at) cfg_tt_we = 1'b1;
      tick();
      lat++;
      cfg_tt_we = 1'b0;
      if (lat == cfg_at) drop = cfg_drop;
      if (lat == cfg_at + 1) drop_after = cfg_drop;
    end
    res = out_vec;
    repeat (rdy_gap) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 0; out_ready = 0; in_vec = '0;
    cfg_tt_we = 0; cfg_conn_we = 0; cfg_neuron = 0; cfg_tt_addr = 0;
    cfg_tt_bit = 0; cfg_conn_slot = 0; cfg_conn_idx = 0;
    repeat (3) tick();
    vectors++; if (in_ready !== 1'b1)   begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0)  begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (out_vec !== 16'h0)   begin miscompares++; $display("FAIL reset_out_vec: got %h want 0000", out_vec); end
    vectors++; if (busy !== 1'b0)       begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (cfg_drop !== 1'b0)   begin miscompares++; $display("FAIL reset_cfg_drop: got %b want 0", cfg_drop); end
    rst = 1'b0;
    tick();
    vectors++; if (in_ready !== 1'b1)   begin miscompares++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_all_zero();
    logic [15:0] res; int lat, acc; logic d, da;
    for (int n = 0; n < NEURONS; n++)
      for (int a = 0; a < 256; a++)
        cfg_wr(n, a, (a == 0) && (n % 2 == 0), a < 8, a % 8, 0);
    run_one(64'h0, 0, 0, -1, res, lat, acc, d, da);
    vectors++; if (res !== 16'h5555) begin miscompares++; $display("FAIL all_zero_vec: got %h want 5555", res); end
    vectors++; if (lat !== 17)       begin miscompares++; $display("FAIL all_zero_latency: got %0d want 17", lat); end
  endtask

  task automatic test_fanin();
    logic [15:0] res; int lat, acc; logic d, da;
    for (int j = 0; j < 8; j++) cfg_wr(3, j, 1'b0, 1'b1, j, j);
    cfg_wr(3, 'hA5, 1'b1, 1'b0, 0, 0);
    vectors++; if (cfg_drop !== 1'b0) begin miscompares++; $display("FAIL idle_write_drop: got %b want 0", cfg_drop); end
    run_one(64'hDEAD_BEEF_0000_00A5, 0, 0, -1, res, lat, acc, d, da);
    vectors++; if (res !== 16'h0008) begin miscompares++; $display("FAIL fanin_a5: got %h want 0008", res); end
    run_one(64'h0123_4567_89AB_CDA4, 1, 2, -1, res, lat, acc, d, da);
    vectors++; if (res !== 16'h5555) begin miscompares++; $display("FAIL fanin_a4: got %h want 5555", res); end
  endtask

  task automatic test_accept_with_cfg();
    logic [15:0] res; int lat, acc; logic d, da;
    cfg_neuron = 4'd3; cfg_tt_addr = 8'hA4; cfg_tt_bit = 1'b1;
    run_one(64'h0000_0000_0000_00A4, 0, 0, 0, res, lat, acc, d, da);
    vectors++; if (d !== 1'b0)       begin miscompares++; $display("FAIL accept_cfg_drop: got %b want 0", d); end
    vectors++; if (res !== 16'h555D) begin miscompares++; $display("FAIL accept_cfg_vec: got %h want 555d", res); end
    cfg_wr(3, 'hA4, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_backpressure();
    int t;
    in_vec = 64'h00A4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 100) begin tick(); t++; end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_vec = 64'h00A5;
      tick();
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, out_valid); end
      vectors++; if (out_vec !== 16'h5555) begin miscompares++; $display("FAIL bp_out_vec[%0d]: got %h want 5555", i, out_vec); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_cfg_during_run();
    logic [15:0] res; int lat, acc; logic d, da;
    cfg_neuron = 4'd3; cfg_tt_addr = 8'hA5; cfg_tt_bit = 1'b0;
    run_one(64'h00A5, 0, 0, 5, res, lat, acc, d, da);
    vectors++; if (d !== 1'b1)       begin miscompares++; $display("FAIL run_cfg_drop: got %b want 1", d); end
    vectors++; if (da !== 1'b0)      begin miscompares++; $display("FAIL run_cfg_drop_clear: got %b want 0", da); end
    vectors++; if (res !== 16'h0008) begin miscompares++; $display("FAIL run_cfg_vec: got %h want 0008", res); end
    run_one(64'h00A5, 0, 0, -1, res, lat, acc, d, da);
    vectors++; if (res !== 16'h0008) begin miscompares++; $display("FAIL run_cfg_table_kept: got %h want 0008", res); end
  endtask

  task automatic test_reset_midrun();
    logic [15:0] res; int lat, acc; logic d, da;
    in_vec = 64'h00A4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midrun_busy: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrun_rst_valid: got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL midrun_rst_ready: got %b want 1", in_ready); end
    #2 rst = 1'b0;
    tick();
    run_one(64'h00A5, 0, 0, -1, res, lat, acc, d, da);
    vectors++; if (res !== 16'h0008) begin miscompares++; $display("FAIL midrun_after_vec: got %h want 0008", res); end
    vectors++; if (lat !== 17)       begin miscompares++; $display("FAIL midrun_after_lat: got %0d want 17", lat); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] res, exp; int lat, acc, prev; logic d, da;
    logic [63:0] v;
    for (int n = 0; n < NEURONS; n++)
      for (int a = 0; a < 256; a++)
        cfg_wr(n, a, bit'($urandom % 2), a < 8, a % 8, int'($urandom % 64));
    prev = 0;
    for (int i = 0; i < 200; i++) begin
      v   = {$urandom, $urandom};
      exp = model(v);
      run_one(v, ($urandom % 2) ? 0 : int'($urandom_range(1, 3)),
                 ($urandom % 2) ? 0 : int'($urandom_range(1, 3)), -1, res, lat, acc, d, da);
      vectors++; if (res !== exp) begin miscompares++; $display("FAIL b2b_vec[%0d]: got %h want %h", i, res, exp); end
      vectors++; if (lat !== 17)  begin miscompares++; $display("FAIL b2b_lat[%0d]: got %0d want 17", i, lat); end
      if (i > 0) begin
        vectors++; if (acc - prev < 19) begin miscompares++; $display("FAIL b2b_period[%0d]: got %0d want >=19", i, acc - prev); end
      end
      prev = acc;
    end
    tick();
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL b2b_drain: got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_fanin();
    test_accept_with_cfg();
    test_backpressure();
    test_cfg_during_run();
    test_reset_midrun();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
